param_shift_unit: RTL
=====================

// Module: param_shift_unit
// PURPOSE
//   Parametrised sequential shift unit; next generation of the single-bit left shift register.
//   - Loadable WIDTH-bit register; shifts left or right by a programmable amount.
//   - Modes: logical, arithmetic and rotate; one bit position per clock under a start/busy/done handshake.
//   - Keeps the legacy one-step left shift (shift_enable) so existing datapath controllers reuse it unchanged.
// PARAMETERS
//   WIDTH    16  data register width (>=2)
//   SHAMT_W  5   width of shift-amount input; amounts 0..2^SHAMT_W-1 accepted
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        asynchronous, active-low reset
//   ld            in   1        parallel load of in -> out (IDLE only)
//   in            in   WIDTH    parallel load data
//   shift_enable  in   1        legacy: one logical left shift, LSB<-0 (IDLE only)
//   start         in   1        begin multi-step shift (IDLE only)
//   dir           in   1        0=left, 1=right; sampled at start
//   mode          in   2        00 logical, 01 arithmetic, 10 rotate, 11 serial-fill; sampled at start
//   shamt         in   SHAMT_W  number of single-bit steps; sampled at start
//   ser_in        in   1        fill bit for mode 11, sampled every step
//   out           out  WIDTH    register contents
//   carry         out  1        last bit shifted out of the register
//   busy          out  1        high while in SHIFT
//   done          out  1        one-cycle completion pulse
// BEHAVIOUR
//   - rst low (async): out=0, carry=0, busy=0, done=0, count=0, state=IDLE; holds while low.
//   - States: IDLE, SHIFT, DONE. busy = (state==SHIFT). done = (state==DONE).
//   - IDLE priority at each edge: ld > start > shift_enable > hold.
//     ld: out<=in, carry unchanged. shift_enable: out<={out[W-2:0],0}, carry<=out[W-1].
//   - start, shamt!=0: latch dir/mode; count<=shamt; go SHIFT. start, shamt==0: go DONE, out unchanged.
//   - SHIFT, each edge: one step, count<=count-1. Leave for DONE on the edge where count==1.
//     Total: start edge + shamt step edges; done high in the cycle after the last step.
//   - Left step: out<={out[W-2:0],f}, carry<=out[W-1].
//     f = 0 for logical/arithmetic, out[W-1] for rotate, ser_in for serial-fill.
//   - Right step: out<={f,out[W-1:1]}, carry<=out[0].
//     f = 0 for logical, out[W-1] (sign) for arithmetic, out[0] for rotate, ser_in for serial-fill.
//   - shamt>=WIDTH is legal: logical/arithmetic saturate naturally (all 0 or all sign); rotate wraps mod WIDTH.
//   - ld, start and shift_enable are ignored in SHIFT and DONE; no queuing.
//   - DONE lasts exactly one cycle, then returns to IDLE. A start in that cycle is dropped.
//   - rst asserted mid-operation aborts immediately to the reset state; no done pulse.
// CONFIGURATION
//   PARAM_SHIFT_FAST_EN
//     defined:   start performs the whole shift in one edge via a barrel network (result as if shamt steps applied).
//                State goes directly to DONE; busy never asserts; done one cycle after start.
//     undefined: sequential one-step-per-cycle operation as above (default; smaller area).
//     shift_enable, ld and the reset behaviour are identical in both builds.
// TESTING
//   1. rst low mid-SHIFT (WIDTH=16) -> out=0, busy=0, carry=0 asynchronously; no done pulse.
//   2. ld in=16'h00F1, then shift_enable 3 cycles -> out=16'h0788, carry=0.
//   3. ld 16'h8001; start dir=1 mode=01 shamt=4 -> busy 4 cycles; done pulse; out=16'hF800, carry=0.
//   4. ld 16'h8001; start dir=0 mode=10 shamt=17 -> out=16'h0003, carry=1, done after 17 steps.
//   5. start shamt=0 -> done next cycle, busy never high; out and carry unchanged.
//      ld asserted while busy -> ignored.
//   6. PARAM_SHIFT_FAST_EN build: repeat test 3 -> out=16'hF800 and done one cycle after start; busy stays 0.

Source files
------------

// File: rtl/param_shift_unit_if.sv
// Handshake and data bundle for param_shift_unit.
// master drives the controls, slave is the shift unit.
interface param_shift_unit_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
);
  logic               ld;
  logic [WIDTH-1:0]   in;
  logic               shift_enable;
  logic               start;
  logic               dir;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic               ser_in;
  logic [WIDTH-1:0]   out;
  logic               carry;
  logic               busy;
  logic               done;

  modport master (
    output ld, in, shift_enable, start,
    output dir, mode, shamt, ser_in,
    input  out, carry, busy, done
  );

  modport slave (
    input  ld, in, shift_enable, start,
    input  dir, mode, shamt, ser_in,
    output out, carry, busy, done
  );
endinterface

// File: rtl/param_shift_unit.sv
// Parametrised shift unit: logical/arith/rotate/serial-fill, one bit per clock.
// Define PARAM_SHIFT_FAST_EN for a single-edge barrel shift instead.
module param_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input logic             clk,
  input logic             rst,
  param_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] M_LOG = 2'b00;
  localparam logic [1:0] M_ARI = 2'b01;
  localparam logic [1:0] M_ROT = 2'b10;

  // One single-bit step; returns {carry, data}.
  function automatic logic [WIDTH:0] step_f(
    input logic [WIDTH-1:0] v,
    input logic             d,
    input logic [1:0]       m,
    input logic             s
  );
    logic f;
    unique case (m)
      M_LOG:   f = 1'b0;
      M_ARI:   f = d ? v[WIDTH-1] : 1'b0;
      M_ROT:   f = d ? v[0] : v[WIDTH-1];
      default: f = s;
    endcase
    if (d)
      return {v[0], f, v[WIDTH-1:1]};
    else
      return {v[WIDTH-1], v[WIDTH-2:0], f};
  endfunction

`ifdef PARAM_SHIFT_FAST_EN
  localparam int MAX_STEPS = (1 << SHAMT_W) - 1;

  // Unrolled chain of steps, each stage bypassed past the amount.
  function automatic logic [WIDTH:0] barrel_f(
    input logic [WIDTH-1:0]   v,
    input logic               c,
    input logic [SHAMT_W-1:0] n,
    input logic               d,
    input logic [1:0]         m,
    input logic               s
  );
    logic [WIDTH:0] r;
    r = {c, v};
    for (int i = 0; i < MAX_STEPS; i++) begin
      if (i < int'(n))
        r = step_f(r[WIDTH-1:0], d, m, s);
    end
    return r;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

`ifndef PARAM_SHIFT_FAST_EN
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
`ifndef PARAM_SHIFT_FAST_EN
      count_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= M_LOG;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
`ifndef PARAM_SHIFT_FAST_EN
      count_q <= count_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
`endif
    end
  end

  // Next state and datapath; controls only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
`ifndef PARAM_SHIFT_FAST_EN
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ld) begin
          out_d = bus.in;
        end else if (bus.start) begin
`ifdef PARAM_SHIFT_FAST_EN
          {carry_d, out_d} = barrel_f(out_q, carry_q,
                                      bus.shamt, bus.dir,
                                      bus.mode, bus.ser_in);
          state_d = DONE;
`else
          if (bus.shamt == '0) begin
            state_d = DONE;
          end else begin
            dir_d   = bus.dir;
            mode_d  = bus.mode;
            count_d = bus.shamt;
            state_d = SHIFT;
          end
`endif
        end else if (bus.shift_enable) begin
          out_d   = {out_q[WIDTH-2:0], 1'b0};
          carry_d = out_q[WIDTH-1];
        end
      end
      SHIFT: begin
`ifndef PARAM_SHIFT_FAST_EN
        {carry_d, out_d} = step_f(out_q, dir_q,
                                  mode_q, bus.ser_in);
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_W'(1))
          state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);

endmodule
